vga_text_render: RTL and testbench
==================================

Name: vga_text_render

Overview:
- Text-mode pixel stage sitting directly downstream of vga_sync.
- Consumes the registered timing outputs of vga_sync (hsync, vsync, video_active, pixel_x, pixel_y) and renders an 80x30 grid of 8x16 glyphs.
- Fetches glyphs through a character RAM read port and a font ROM read port; both memories are external to this block.
- Drives 12-bit RGB plus sync and data-enable, all delayed so they stay aligned with the pixels.
- Overlays a blinking underline cursor.

Parameters:
- COLS, 80, text columns per row; char_addr = row*COLS + col.
- ROWS, 30, text rows; ROWS*16 must equal 480.
- BLINK_FRAMES, 32, frames per cursor blink half-period.

Ports:
- clk  in  1  pixel clock (25 MHz), the same clock as vga_sync
- rst  in  1  synchronous, active-high reset
- hsync_in  in  1  from vga_sync, active low
- vsync_in  in  1  from vga_sync, active low
- video_active_in  in  1  from vga_sync
- pixel_x  in  10  from vga_sync
- pixel_y  in  10  from vga_sync
- char_addr  out  12  character RAM read address, combinational
- char_data  in  16  [7:0] glyph code, [11:8] fg index, [15:12] bg index; valid 1 cycle after address
- font_addr  out  12  {glyph code, glyph row[3:0]}, combinational
- font_data  in  8  glyph row bits, MSB = leftmost pixel; valid 1 cycle after address
- cursor_en  in  1  cursor overlay enable
- cursor_col  in  7  cursor column
- cursor_row  in  5  cursor row
- rgb  out  12  {R[3:0], G[3:0], B[3:0]}
- hsync_out  out  1  hsync_in delayed 3 cycles
- vsync_out  out  1  vsync_in delayed 3 cycles
- de_out  out  1  video_active_in delayed 3 cycles

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - rgb=0, hsync_out=1, vsync_out=1, de_out=0.
  - All pipeline registers cleared.
  - Blink frame counter=0, blink phase=0 (cursor visible).
  - The first valid output appears 3 cycles after rst deasserts.
  - Reset mid-frame discards any in-flight pixels; there is no recovery state.
- Pipeline: inputs sampled at edge E0; outputs registered at E3. Latency is exactly 3 cycles for rgb, hsync_out, vsync_out and de_out.
- Stage A (combinational from inputs):
  - char_addr = pixel_y[8:4]*COLS + pixel_x[9:3].
  - Multiply is shift-add ((r<<6)+(r<<4) for COLS=80), 12-bit result, no overflow for in-range coordinates.
  - The address is computed identically in blanking; the data returned in blanking is don't-care.
- E1 registers: pixel_y[3:0], pixel_x[2:0], cell col/row, and the delayed sync and active signals.
- Stage B (combinational): font_addr = {char_data[7:0], row_q[3:0]}.
- E2 registers: fg/bg indices, bit index, cursor-hit flag, and the delayed sync and active signals.
  - Cursor-hit = cursor_en & (col==cursor_col) & (row==cursor_row) & (glyph row >= 14) & (blink phase==0).
- Stage C:
  - pix = font_data[7 - bit_index].
  - Colour index = (pix XOR cursor_hit) ? fg : bg.
  - rgb = PALETTE[index] when delayed active=1, else 12'h000, registered at E3.
- Blink:
  - A falling edge of vsync_in (previous=1, current=0) increments the frame counter.
  - When the counter reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
  - The blink phase is sampled in stage A, so a toggle mid-frame takes effect on the next sampled pixel (no tearing in practice, because the toggle occurs during vsync).
- Boundaries:
  - cursor_col >= COLS or cursor_row >= ROWS never matches; no cursor is drawn.
  - pixel_x=639 maps to col 79, bit 7.
  - pixel_y=479 maps to row 29, glyph row 15.
- Memory reads every cycle with no handshake; both memories must be fixed 1-cycle-latency synchronous reads.

Decomposition:
- Package vga_text_pkg holds:
  - Constants CELL_W=8, CELL_H=16, CURSOR_FIRST_LINE=14.
  - A 16-entry 12-bit CGA palette constant: 0=000, 1=00A, 2=0A0, 3=0AA, 4=A00, 5=A0A, 6=A50, 7=AAA, 8=555, 9=55F, A=5F5, B=5FF, C=F55, D=F5F, E=FF5, F=FFF.
  - Field-slice constants for char_data.
- One sub-module, vga_cursor_blink: frame counter, vsync edge detect and blink phase output.

Test Plan:
- Reset: assert rst for 2 cycles mid-line -> rgb=000, hsync_out=1, vsync_out=1, de_out=0 during reset; first valid pixel emerges 3 cycles after rst deasserts.
- Alignment: drive vga_sync-style timing with hsync_in low at x=656..751 -> hsync_out low on exactly the same counts shifted by 3 cycles; de_out high for 640 cycles per line.
- Glyph render: RAM cell (col 2, row 1) = 16'h1F41, font ROM glyph 0x41 row 5 = 8'h81 at pixel (16..23, 21):
  - char_addr=82 and font_addr=0x415 are driven.
  - rgb=FFF at x=16 and x=23; rgb=00A at x=17..22.
- Cursor: cursor_en=1, col=2, row=1, blink phase 0, font row 14 = 8'h00, attr 16'h1F41 -> rgb=FFF for x=16..23 at y=30,31; rgb=00A at y=29.
- Blink: 32 vsync falling edges -> phase toggles and the cursor is not drawn; 32 more restore it. A cursor at col=80 is never drawn.
- Blanking: pixel_x=700 with video_active_in=0 -> rgb=000 three cycles later, regardless of memory data.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared constants for the text-mode renderer: cell geometry, char_data field layout,
// the 16-colour CGA palette and the 80-column address helper.
package vga_text_pkg;

  localparam int CELL_W            = 8;
  localparam int CELL_H            = 16;
  localparam int CURSOR_FIRST_LINE = 14;

  localparam int GLYPH_LSB = 0;
  localparam int GLYPH_MSB = 7;
  localparam int FG_LSB    = 8;
  localparam int FG_MSB    = 11;
  localparam int BG_LSB    = 12;
  localparam int BG_MSB    = 15;

  localparam logic [11:0] PALETTE [0:15] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  // row*80 + col built from two shifts so no multiplier is inferred
  function automatic logic [11:0] cell_addr80(input logic [4:0] row, input logic [6:0] col);
    return {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
  endfunction

endpackage

// File: rtl/vga_text_render_if.sv
// Read ports of the external character RAM and font ROM; both are 1-cycle synchronous reads.
interface vga_text_render_if;
  logic [11:0] char_addr;
  logic [15:0] char_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;

  modport master (output char_addr, output font_addr, input char_data, input font_data);
  modport slave  (input char_addr, input font_addr, output char_data, output font_data);
endinterface

// File: rtl/vga_cursor_blink.sv
// Counts vsync falling edges and toggles the cursor blink phase every BLINK_FRAMES frames.
module vga_cursor_blink #(
  parameter int BLINK_FRAMES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vsync,
  output logic o_blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic             r_vs_prev;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_phase;
  logic             w_vs_fall;

  assign w_vs_fall     = r_vs_prev & ~i_vsync;
  assign o_blink_phase = r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_prev   <= 1'b1;
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_vs_prev <= i_vsync;
      if (w_vs_fall) begin
        if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_text_render.sv
// Text-mode pixel stage: 80x30 cells of 8x16 glyphs with blinking underline cursor,
// three-cycle pipeline keeping rgb, syncs and data-enable aligned.
module vga_text_render
  import vga_text_pkg::*;
#(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     video_active_in,
  input  logic [9:0]               pixel_x,
  input  logic [9:0]               pixel_y,
  vga_text_render_if.master        mem,
  input  logic                     cursor_en,
  input  logic [6:0]               cursor_col,
  input  logic [4:0]               cursor_row,
  output logic [11:0]              rgb,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     de_out
);

  logic [6:0] w_col;
  logic [4:0] w_row;
  logic       w_blink;
  logic       w_unused_y9;

  logic [3:0] r_line_p1;
  logic [2:0] r_bit_p1;
  logic [6:0] r_col_p1;
  logic [4:0] r_row_p1;
  logic       r_blink_p1;
  logic       r_hs_p1, r_vs_p1, r_vld_p1;

  logic       w_cursor_hit;
  logic [3:0] r_fg_p2, r_bg_p2;
  logic [2:0] r_bit_p2;
  logic       r_hit_p2;
  logic       r_hs_p2, r_vs_p2, r_vld_p2;

  logic       w_pix;
  logic [3:0] w_idx;

  vga_cursor_blink #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk          (clk),
    .rst          (rst),
    .i_vsync      (vsync_in),
    .o_blink_phase(w_blink)
  );

  // ---- stage A: cell coordinates and character RAM address ----
  assign w_col       = pixel_x[9:3];
  assign w_row       = pixel_y[8:4];
  assign w_unused_y9 = pixel_y[9];

  generate
    if (COLS == 80) begin : g_addr80
      assign mem.char_addr = cell_addr80(w_row, w_col);
    end else begin : g_addr_mul
      assign mem.char_addr = 12'(int'(w_row) * COLS + int'(w_col));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_p1  <= '0;
      r_bit_p1   <= '0;
      r_col_p1   <= '0;
      r_row_p1   <= '0;
      r_blink_p1 <= 1'b0;
      r_hs_p1    <= 1'b1;
      r_vs_p1    <= 1'b1;
      r_vld_p1   <= 1'b0;
    end else begin
      r_line_p1  <= pixel_y[3:0];
      r_bit_p1   <= pixel_x[2:0];
      r_col_p1   <= w_col;
      r_row_p1   <= w_row;
      r_blink_p1 <= w_blink;
      r_hs_p1    <= hsync_in;
      r_vs_p1    <= vsync_in;
      r_vld_p1   <= video_active_in;
    end
  end

  // ---- stage B: font ROM address and cursor match ----
  assign mem.font_addr = {mem.char_data[GLYPH_MSB:GLYPH_LSB], r_line_p1};

  // Out-of-range cursor positions must never match blanking-area cells either
  assign w_cursor_hit = cursor_en & (r_col_p1 == cursor_col) & (r_row_p1 == cursor_row)
                      & (r_line_p1 >= 4'(CURSOR_FIRST_LINE)) & ~r_blink_p1
                      & (int'(cursor_col) < COLS) & (int'(cursor_row) < ROWS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fg_p2  <= '0;
      r_bg_p2  <= '0;
      r_bit_p2 <= '0;
      r_hit_p2 <= 1'b0;
      r_hs_p2  <= 1'b1;
      r_vs_p2  <= 1'b1;
      r_vld_p2 <= 1'b0;
    end else begin
      r_fg_p2  <= mem.char_data[FG_MSB:FG_LSB];
      r_bg_p2  <= mem.char_data[BG_MSB:BG_LSB];
      r_bit_p2 <= r_bit_p1;
      r_hit_p2 <= w_cursor_hit;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- stage C: pixel select, cursor invert, palette lookup ----
  assign w_pix = mem.font_data[3'd7 - r_bit_p2];
  assign w_idx = (w_pix ^ r_hit_p2) ? r_fg_p2 : r_bg_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      de_out    <= 1'b0;
    end else begin
      rgb       <= r_vld_p2 ? PALETTE[w_idx] : 12'h000;
      hsync_out <= r_hs_p2;
      vsync_out <= r_vs_p2;
      de_out    <= r_vld_p2;
    end
  end

endmodule

// File: tb/tb_vga_text_render.sv
// Bench for vga_text_render: memory models, table vectors and a 3-deep scoreboard queue.
module tb_vga_text_render;

  logic        clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst, hsync_in, vsync_in, video_active_in, cursor_en;
  logic [9:0]  pixel_x, pixel_y;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, de_out;

  vga_text_render_if mem ();

  vga_text_render dut (
    .clk            (clk),
    .rst            (rst),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .video_active_in(video_active_in),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .mem            (mem),
    .cursor_en      (cursor_en),
    .cursor_col     (cursor_col),
    .cursor_row     (cursor_row),
    .rgb            (rgb),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out),
    .de_out         (de_out)
  );

  logic [15:0] cram [0:4095];
  logic [7:0]  font [0:4095];

  always @(posedge clk) begin
    mem.char_data <= cram[mem.char_addr];
    mem.font_data <= font[mem.font_addr];
  end

  localparam logic [11:0] PAL [0:15] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } exp_t;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        act;
    logic        cen;
    logic [11:0] rgb;
  } vec_t;

  localparam exp_t RST_EXP = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, de: 1'b0};

  exp_t  q[$];
  string qn[$];
  vec_t  tbl[$];
  int    checks = 0;
  int    errors = 0;
  int    n_de = 0;
  int    n_hs = 0;
  bit    prev_rst = 1'b0;
  int    m_cnt = 0;
  bit    m_phase = 1'b0;
  bit    m_vs_prev = 1'b1;

  function automatic logic [11:0] model_rgb(input logic [9:0] x, input logic [9:0] y, input logic act);
    logic [6:0]  col;
    logic [4:0]  row;
    logic [11:0] a;
    logic [15:0] cd;
    logic [7:0]  fd;
    logic        pix, hit;
    logic [3:0]  idx;
    col = x[9:3];
    row = y[8:4];
    a   = 12'(int'(row) * 80 + int'(col));
    cd  = cram[a];
    fd  = font[{cd[7:0], y[3:0]}];
    pix = fd[3'd7 - x[2:0]];
    hit = cursor_en && (col == cursor_col) && (row == cursor_row) && (y[3:0] >= 4'd14)
          && !m_phase && (cursor_col < 7'd80) && (cursor_row < 5'd30);
    idx = (pix ^ hit) ? cd[11:8] : cd[15:12];
    return act ? PAL[idx] : 12'h000;
  endfunction

  task automatic check_out(input exp_t e, input string nm);
    checks++;
    if (nm == "line") begin
      n_de += int'(de_out);
      n_hs += int'(!hsync_out);
    end
    if (rgb !== e.rgb || hsync_out !== e.hs || vsync_out !== e.vs || de_out !== e.de) begin
      errors++;
      $display("FAIL %s: got rgb=%h hs=%b vs=%b de=%b, want rgb=%h hs=%b vs=%b de=%b",
               nm, rgb, hsync_out, vsync_out, de_out, e.rgb, e.hs, e.vs, e.de);
    end
  endtask

  task automatic check_val(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, got, got, want, want);
    end
  endtask

  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic act,
                      input logic hs, input logic vs, input logic rs,
                      input logic use_tbl, input logic [11:0] trgb, input string nm);
    exp_t e;
    @(negedge clk);
    if (q.size() == 3) check_out(q.pop_front(), qn.pop_front());
    rst = rs; pixel_x = x; pixel_y = y; video_active_in = act; hsync_in = hs; vsync_in = vs;
    if (rs) begin
      if (!prev_rst) begin
        q.delete(); qn.delete();
        repeat (2) begin q.push_back(RST_EXP); qn.push_back("reset"); end
      end
      q.push_back(RST_EXP); qn.push_back("reset");
      m_cnt = 0; m_phase = 1'b0; m_vs_prev = 1'b1;
    end else begin
      e.rgb = use_tbl ? trgb : model_rgb(x, y, act);
      e.hs  = hs;
      e.vs  = vs;
      e.de  = act;
      q.push_back(e); qn.push_back(nm);
      if (m_vs_prev && !vs) begin
        if (m_cnt == 31) begin m_cnt = 0; m_phase = ~m_phase; end
        else m_cnt++;
      end
      m_vs_prev = vs;
    end
    prev_rst = rs;
  endtask

  task automatic px(input int x, input int y, input string nm);
    step(10'(x), 10'(y), (x < 640) ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) step(10'd700, 10'd500, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, "idle");
  endtask

  task automatic vpulses(input int n);
    repeat (n) begin
      step(10'd700, 10'd500, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, "vpulse");
      step(10'd700, 10'd500, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, "vpulse");
    end
  endtask

  task automatic sweep_cursor(input string nm);
    for (int x = 16; x < 24; x++) px(x, 30, nm);
    idle(3);
  endtask

  function automatic void add(input int x, input int y, input bit act, input bit cen, input logic [11:0] c);
    vec_t v;
    v.x = 10'(x); v.y = 10'(y); v.act = act; v.cen = cen; v.rgb = c;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; video_active_in = 1'b0;
    pixel_x = '0; pixel_y = '0;
    cursor_en = 1'b0; cursor_col = 7'd2; cursor_row = 5'd1;

    for (int i = 0; i < 4096; i++) begin
      cram[i] = 16'($urandom);
      font[i] = 8'($urandom);
    end
    cram[82]    = 16'h1F41;
    font[12'h415] = 8'h81;
    font[12'h41D] = 8'h00;
    font[12'h41E] = 8'h00;
    font[12'h41F] = 8'h00;
    cram[2399]  = 16'h2C07;
    font[12'h07F] = 8'h01;

    // Power-on reset, then a line interrupted by a 2-cycle reset
    repeat (3) step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h0, "reset");
    for (int x = 0; x < 40; x++) begin
      if (x == 20 || x == 21)
        step(10'(x), 10'd21, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h0, "reset");
      else
        px(x, 21, "midline");
    end
    idle(3);

    // Hand-computed vectors
    for (int x = 17; x < 23; x++) add(x, 21, 1, 0, 12'h00A);
    add(16, 21, 1, 0, 12'hFFF);
    add(23, 21, 1, 0, 12'hFFF);
    add(639, 479, 1, 0, 12'hF55);
    add(632, 479, 1, 0, 12'h0A0);
    add(700, 21, 0, 0, 12'h000);
    add(700, 479, 0, 0, 12'h000);
    for (int x = 16; x < 24; x++) add(x, 30, 1, 1, 12'hFFF);
    for (int x = 16; x < 24; x++) add(x, 31, 1, 1, 12'hFFF);
    for (int x = 16; x < 24; x++) add(x, 29, 1, 1, 12'h00A);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].cen != cursor_en) begin
        idle(3);
        cursor_en = tbl[i].cen;
      end
      step(tbl[i].x, tbl[i].y, tbl[i].act, 1'b1, 1'b1, 1'b0, 1'b1, tbl[i].rgb, "table");
    end
    idle(3);
    cursor_en = 1'b0;

    // Combinational address outputs
    idle(3);
    px(16, 21, "addr_px");
    #1 check_val("char_addr", int'(mem.char_addr), 82);
    @(posedge clk);
    #1 check_val("font_addr", int'(mem.font_addr), 'h415);
    idle(3);

    // Full line with vga_sync-style hsync pulse
    for (int x = 0; x < 800; x++)
      step(10'(x), 10'd21, (x < 640) ? 1'b1 : 1'b0, (x >= 656 && x <= 751) ? 1'b0 : 1'b1,
           1'b1, 1'b0, 1'b0, 12'h0, "line");
    idle(3);
    check_val("de_out_count", n_de, 640);
    check_val("hsync_low_count", n_hs, 96);

    // Blink: 31 edges keep the cursor, the 32nd hides it, 32 more restore it
    cursor_en = 1'b1;
    vpulses(31);
    sweep_cursor("blink31");
    vpulses(1);
    sweep_cursor("blink_off");
    for (int x = 16; x < 24; x++)
      step(10'(x), 10'd30, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h00A, "blink_off_tbl");
    idle(3);
    vpulses(32);
    for (int x = 16; x < 24; x++)
      step(10'(x), 10'd30, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'hFFF, "blink_on_tbl");
    idle(3);

    // Cursor outside the grid is never drawn
    cursor_col = 7'd80;
    for (int x = 600; x < 700; x++) px(x, 30, "cursor_col80");
    idle(3);
    cursor_col = 7'd2;
    cursor_row = 5'd30;
    for (int x = 8; x < 32; x++) px(x, 30, "cursor_row30");
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
